// File: rtl/alu_issue_if.sv
// alu_issue_if: command, ALU-side and result handshake signals of the issue stage.
// The slave view belongs to the issue stage; the master view drives commands,
// models the ALU and consumes results.
interface alu_issue_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_aluop;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [3:0]   in_tag;

  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [4:0]   alu_op;
  logic [N-1:0] alu_result;
  logic         alu_neg;
  logic         alu_ovf;
  logic         alu_cout;

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [3:0]   out_flags;
  logic         out_err;
  logic [3:0]   out_tag;

  modport slave (
    input  in_valid, in_aluop, in_a, in_b, in_tag,
    input  alu_result, alu_neg, alu_ovf, alu_cout,
    input  out_ready,
    output in_ready,
    output alu_a, alu_b, alu_op,
    output out_valid, out_result, out_flags, out_err, out_tag
  );

  modport master (
    output in_valid, in_aluop, in_a, in_b, in_tag,
    output alu_result, alu_neg, alu_ovf, alu_cout,
    output out_ready,
    input  in_ready,
    input  alu_a, alu_b, alu_op,
    input  out_valid, out_result, out_flags, out_err, out_tag
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: command FIFO -> operand register -> result register in front
// of a combinational ALU. Illegal/unsupported opcodes are screened when they
// enter the operand register; result flags are masked per opcode.
module alu_issue_stage #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus,
  output logic       busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [4:0] OP_ADDS = 5'b00001;
  localparam logic [4:0] OP_ADDU = 5'b00010;

  logic [N-1:0]  fifo_a   [DEPTH];
  logic [N-1:0]  fifo_b   [DEPTH];
  logic [4:0]    fifo_op  [DEPTH];
  logic [3:0]    fifo_tag [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          op_valid_q, op_valid_d, op_err_q, op_err_d;
  logic [N-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [4:0]    op_code_q, op_code_d;
  logic [3:0]    op_tag_q, op_tag_d;
  logic          out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [N-1:0]  out_result_q, out_result_d;
  logic [3:0]    out_flags_q, out_flags_d, out_tag_q, out_tag_d;

  logic          push, pop, advance;
  logic [4:0]    head_op;
  logic          head_legal, pass_nv, pass_c, res_zero;

  function automatic logic op_legal(input logic [4:0] op);
    return !((op == 5'd0) || (op > 5'd19) || (op == 5'd4) || (op == 5'd5) || (op == 5'd7));
  endfunction

  // in_ready looks only at registered occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign bus.in_ready = (count_q < FULL);
  assign push         = bus.in_valid & bus.in_ready;
  assign advance      = op_valid_q & (~out_valid_q | bus.out_ready);
  assign pop          = (count_q != '0) & (~op_valid_q | advance);
  assign head_op      = fifo_op[rd_ptr_q];
  assign head_legal   = op_legal(head_op);

  // Screened ops carry alu_op 0, so the opcode compares also mask their flags.
  assign pass_nv  = (op_code_q == OP_ADDS) | (op_code_q == OP_ADDU);
  assign pass_c   = (op_code_q == OP_ADDU);
  assign res_zero = ~op_err_q & (bus.alu_result == '0);

  assign bus.alu_a      = op_a_q;
  assign bus.alu_b      = op_b_q;
  assign bus.alu_op     = op_code_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_tag    = out_tag_q;
  assign busy           = (count_q != '0) | op_valid_q | out_valid_q;

  // FIFO storage; not reset, entries are qualified by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr_q]   <= bus.in_a;
      fifo_b[wr_ptr_q]   <= bus.in_b;
      fifo_op[wr_ptr_q]  <= bus.in_aluop;
      fifo_tag[wr_ptr_q] <= bus.in_tag;
    end
  end

  // Next state of pointers, occupancy, operand register and result register.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    op_valid_d   = op_valid_q;
    op_err_d     = op_err_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    op_tag_d     = op_tag_q;
    out_valid_d  = out_valid_q;
    out_err_d    = out_err_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    out_tag_d    = out_tag_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      op_valid_d = 1'b1;
      op_err_d   = ~head_legal;
      op_a_d     = fifo_a[rd_ptr_q];
      op_b_d     = fifo_b[rd_ptr_q];
      op_code_d  = head_legal ? head_op : 5'd0;
      op_tag_d   = fifo_tag[rd_ptr_q];
    end else if (advance) begin
      op_valid_d = 1'b0;
    end

    if (advance) begin
      out_valid_d  = 1'b1;
      out_err_d    = op_err_q;
      out_tag_d    = op_tag_q;
      out_result_d = op_err_q ? '0 : bus.alu_result;
      out_flags_d  = {pass_c & bus.alu_cout, pass_nv & bus.alu_neg,
                      pass_nv & bus.alu_ovf, res_zero};
    end else if (out_valid_q & bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      op_valid_q   <= 1'b0;
      op_err_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      op_tag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
      out_tag_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      op_valid_q   <= op_valid_d;
      op_err_q     <= op_err_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      op_tag_q     <= op_tag_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      out_tag_q    <= out_tag_d;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed tests for alu_issue_stage with a small
// combinational ALU model and a result collector.
module tb_alu_issue_stage;
  logic clk;
  logic rst_n;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  alu_issue_if #(.N(32)) bus ();

  alu_issue_stage #(.N(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: 1/2 add (2 reports unsigned overflow as ovf), 3 sub, 6 and,
  // 8 xor, anything else or. Flags are always produced so masking is visible.
  logic [32:0] alu_sum;
  assign alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  always_comb begin
    case (bus.alu_op)
      5'd1, 5'd2: bus.alu_result = alu_sum[31:0];
      5'd3:       bus.alu_result = bus.alu_a - bus.alu_b;
      5'd6:       bus.alu_result = bus.alu_a & bus.alu_b;
      5'd8:       bus.alu_result = bus.alu_a ^ bus.alu_b;
      default:    bus.alu_result = bus.alu_a | bus.alu_b;
    endcase
    bus.alu_neg  = bus.alu_result[31];
    bus.alu_cout = alu_sum[32];
    if (bus.alu_op == 5'd2) bus.alu_ovf = alu_sum[32];
    else bus.alu_ovf = (bus.alu_a[31] == bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
  end

  // Result collector: a handshake seen at the negedge completes on the next posedge.
  logic [31:0] res_q[$];
  logic [3:0]  tag_q[$];
  logic [3:0]  flg_q[$];
  logic        err_q[$];
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      res_q.push_back(bus.out_result);
      tag_q.push_back(bus.out_tag);
      flg_q.push_back(bus.out_flags);
      err_q.push_back(bus.out_err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_results();
    res_q.delete(); tag_q.delete(); flg_q.delete(); err_q.delete();
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_aluop = op; bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout tag=%0d in_ready stayed 0", tag);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int k = 0;
    while (res_q.size() < n && k < 200) begin @(posedge clk); #1; k++; end
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_aluop = 0; bus.in_a = 0; bus.in_b = 0; bus.in_tag = 0;
    bus.out_ready = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 69'd0) begin errors++;
      $display("FAIL reset_alu_regs got a=%h b=%h op=%h exp all 0", bus.alu_a, bus.alu_b, bus.alu_op); end
    checks++; if ({bus.out_result, bus.out_flags, bus.out_err, bus.out_tag} !== 41'd0) begin errors++;
      $display("FAIL reset_out_regs got res=%h flags=%b err=%b tag=%h exp all 0",
               bus.out_result, bus.out_flags, bus.out_err, bus.out_tag); end
  endtask

  task automatic test_single_op();
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1; bus.in_aluop = 5'b00010; bus.in_a = 32'hFFFF_FFFF; bus.in_b = 32'd1;
    bus.in_tag = 4'd5; bus.out_ready = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_push_accept busy got=%b exp=1", busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_T1_valid got=%b exp=0", bus.out_valid); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_T2_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'hFFFF_FFFF || bus.alu_b !== 32'd1 || bus.alu_op !== 5'b00010) begin errors++;
      $display("FAIL single_op_reg got a=%h b=%h op=%b exp a=ffffffff b=1 op=00010", bus.alu_a, bus.alu_b, bus.alu_op); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_T3_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_result !== 32'd0 || bus.out_flags !== 4'b1011 || bus.out_err !== 1'b0 || bus.out_tag !== 4'd5) begin errors++;
      $display("FAIL single_result got res=%h flags=%b err=%b tag=%0d exp res=0 flags=1011 err=0 tag=5",
               bus.out_result, bus.out_flags, bus.out_err, bus.out_tag); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL single_drain got valid=%b busy=%b exp 0 0", bus.out_valid, busy); end
  endtask

  task automatic test_illegal_ops();
    logic [31:0] exp_res [7] = '{32'd0, 32'd0, 32'hF000_F000, 32'd0, 32'd3, 32'd0, 32'd0};
    logic        exp_err [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    clear_results();
    bus.out_ready = 0;
    send(5'b00000, 32'd5, 32'd7, 4'd1);
    send(5'b00100, 32'd5, 32'd7, 4'd2);
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd1 || bus.out_err !== 1'b1 ||
                  bus.out_result !== 32'd0 || bus.out_flags !== 4'd0) begin errors++;
      $display("FAIL illegal_held got valid=%b tag=%0d err=%b res=%h flags=%b exp 1 1 1 0 0",
               bus.out_valid, bus.out_tag, bus.out_err, bus.out_result, bus.out_flags); end
    checks++; if (bus.alu_op !== 5'd0 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin errors++;
      $display("FAIL unsupported_alu_op got op=%b a=%h b=%h exp op=00000 a=5 b=7", bus.alu_op, bus.alu_a, bus.alu_b); end
    bus.out_ready = 1;
    send(5'b00110, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3);
    send(5'd20, 32'd1, 32'd2, 4'd4);
    send(5'd19, 32'd1, 32'd2, 4'd5);
    send(5'b00101, 32'd1, 32'd2, 4'd6);
    send(5'b00111, 32'd1, 32'd2, 4'd7);
    wait_results(7);
    checks++; if (res_q.size() != 7) begin errors++; $display("FAIL illegal_count got=%0d exp=7", res_q.size()); end
    for (int i = 0; i < 7 && i < res_q.size(); i++) begin
      checks++;
      if (tag_q[i] !== 4'(i + 1) || res_q[i] !== exp_res[i] || err_q[i] !== exp_err[i] || flg_q[i] !== 4'd0) begin
        errors++;
        $display("FAIL illegal_seq[%0d] got tag=%0d res=%h err=%b flags=%b exp tag=%0d res=%h err=%b flags=0000",
                 i, tag_q[i], res_q[i], err_q[i], flg_q[i], i + 1, exp_res[i], exp_err[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s_res;
    logic [3:0]  s_flags, s_tag;
    logic        s_err;
    clear_results();
    bus.out_ready = 0;
    for (int i = 0; i < 6; i++) send(5'd8, 32'(i) * 32'h0101_0101, 32'h0F0F_0F0F, 4'(i + 8));
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL bp_full got in_ready=%b busy=%b exp 0 1", bus.in_ready, busy); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd8) begin errors++;
      $display("FAIL bp_head got valid=%b tag=%0d exp 1 8", bus.out_valid, bus.out_tag); end
    s_res = bus.out_result; s_flags = bus.out_flags; s_tag = bus.out_tag; s_err = bus.out_err;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== s_res || bus.out_flags !== s_flags ||
          bus.out_tag !== s_tag || bus.out_err !== s_err) begin
        errors++;
        $display("FAIL bp_stable[%0d] got valid=%b res=%h tag=%0d exp valid=1 res=%h tag=%0d",
                 c, bus.out_valid, bus.out_result, bus.out_tag, s_res, s_tag);
      end
    end
    bus.out_ready = 1;
    wait_results(6);
    checks++; if (res_q.size() != 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", res_q.size()); end
    for (int i = 0; i < 6 && i < res_q.size(); i++) begin
      checks++;
      if (tag_q[i] !== 4'(i + 8) || res_q[i] !== ((32'(i) * 32'h0101_0101) ^ 32'h0F0F_0F0F) ||
          flg_q[i] !== 4'd0 || err_q[i] !== 1'b0) begin
        errors++;
        $display("FAIL bp_seq[%0d] got tag=%0d res=%h flags=%b exp tag=%0d res=%h flags=0000",
                 i, tag_q[i], res_q[i], flg_q[i], i + 8, (32'(i) * 32'h0101_0101) ^ 32'h0F0F_0F0F);
      end
    end
  endtask

  task automatic test_full_push_pop();
    int  sent;
    bit  acc;
    clear_results();
    bus.out_ready = 0;
    for (int i = 0; i < 6; i++) send(5'd8, 32'(i), 32'h100, 4'(i));
    repeat (3) @(posedge clk); #1;
    bus.in_valid = 1; bus.in_aluop = 5'd8; bus.in_a = 32'd6; bus.in_b = 32'h100; bus.in_tag = 4'd6;
    bus.out_ready = 1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_no_push got in_ready=%b exp=0", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop got in_ready=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 0;
    sent = 7;
    for (int c = 0; c < 16; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_aluop = 5'd8; bus.in_a = 32'(sent); bus.in_b = 32'h100; bus.in_tag = 4'(sent);
      bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    bus.in_valid = 0; bus.out_ready = 1;
    wait_results(sent);
    repeat (3) @(posedge clk); #1;
    checks++; if (res_q.size() != sent) begin errors++; $display("FAIL stream_count got=%0d exp=%0d", res_q.size(), sent); end
    for (int i = 0; i < sent && i < res_q.size(); i++) begin
      checks++;
      if (tag_q[i] !== 4'(i) || res_q[i] !== (32'(i) ^ 32'h100)) begin
        errors++;
        $display("FAIL stream_seq[%0d] got tag=%0d res=%h exp tag=%0d res=%h", i, tag_q[i], res_q[i], i % 16, 32'(i) ^ 32'h100);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    clear_results();
    bus.out_ready = 0;
    send(5'd6, 32'hAAAA_0000, 32'hFFFF_FFFF, 4'd9);
    send(5'd6, 32'h0000_5555, 32'hFFFF_FFFF, 4'd10);
    send(5'd6, 32'h1234_5678, 32'hFFFF_FFFF, 4'd11);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL midreset_ctrl got valid=%b busy=%b in_ready=%b exp 0 0 1", bus.out_valid, busy, bus.in_ready); end
    checks++; if ({bus.out_result, bus.out_tag, bus.out_flags, bus.out_err, bus.alu_a, bus.alu_op} !== 78'd0) begin errors++;
      $display("FAIL midreset_data got res=%h tag=%0d alu_a=%h alu_op=%b exp all 0",
               bus.out_result, bus.out_tag, bus.alu_a, bus.alu_op); end
    @(negedge clk);
    rst_n = 1'b1; bus.out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    checks++; if (seen || res_q.size() != 0) begin errors++;
      $display("FAIL midreset_no_output got seen=%b results=%0d exp 0 0", seen, res_q.size()); end
  endtask

  task automatic test_pointer_wrap();
    int          c0, dt;
    logic [31:0] a, b, e;
    clear_results();
    bus.out_ready = 1;
    c0 = cyc;
    for (int i = 0; i < 20; i++)
      send(5'b00011, 32'(i) * 32'h1111 + 32'd7, 32'(i) * 32'h2222 + 32'd7, 4'(i));
    wait_results(20);
    dt = cyc - c0;
    checks++; if (res_q.size() != 20) begin errors++; $display("FAIL wrap_count got=%0d exp=20", res_q.size()); end
    checks++; if (dt > 25) begin errors++; $display("FAIL wrap_throughput got=%0d cycles exp<=25", dt); end
    for (int i = 0; i < 20 && i < res_q.size(); i++) begin
      a = 32'(i) * 32'h1111 + 32'd7;
      b = 32'(i) * 32'h2222 + 32'd7;
      e = a + (~b + 32'd1);
      checks++;
      if (res_q[i] !== e || tag_q[i] !== 4'(i) || flg_q[i] !== {3'b000, (e == 32'd0)} || err_q[i] !== 1'b0) begin
        errors++;
        $display("FAIL wrap_seq[%0d] got res=%h tag=%0d flags=%b err=%b exp res=%h tag=%0d flags=%b err=0",
                 i, res_q[i], tag_q[i], flg_q[i], err_q[i], e, i % 16, {3'b000, (e == 32'd0)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_illegal_ops();
    test_backpressure();
    test_full_push_pop();
    test_reset_midflight();
    test_pointer_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
